rr_arbiter: RTL and testbench

- Parametrised round-robin arbiter; successor to the combinational lowest-bit bitscan.
- Accepts WIDTH request lines and issues one registered one-hot grant.
- A grant is held until the owner signals done, drops its request, or exceeds a hold limit.
- Fairness comes from a rotating priority mask. Sits in front of shared resources (memory port, bus master mux) in the arbitration library.

---
 rtl/arb_pkg.sv | 21 ++
 rtl/rr_arbiter_bitscan.sv | 14 +
 rtl/rr_arbiter.sv | 127 ++++++++++++
 tb/tb_rr_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared arbitration types: FSM state encoding and one-hot to binary index helper.
package arb_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } arb_state_e;

  // Widest one-hot vector the index helper accepts; callers zero-extend to this.
  localparam int unsigned ONEHOT_MAX_W = 256;

  function automatic int unsigned onehot_to_idx(input logic [ONEHOT_MAX_W-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < ONEHOT_MAX_W; i++) begin
      if (oh[i]) idx |= i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter_bitscan.sv
// Combinational lowest-set-bit isolate: returns a one-hot of the lowest set request bit.
module rr_arbiter_bitscan #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] lowest_c,
  output logic             any_c
);

  // Two's-complement trick keeps only the lowest set bit.
  assign lowest_c = req & (~req + WIDTH'(1));
  assign any_c    = |req;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant, owner release and optional hold limit.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned IDX_W    = $clog2(WIDTH),
  parameter int unsigned MAX_HOLD = 0,
  parameter int unsigned CNT_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req,
  input  logic             done,
  output logic [WIDTH-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             busy,
  output logic             timeout
);

  localparam bit              HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = HOLD_EN ? CNT_W'(MAX_HOLD - 1) : '0;

  arb_state_e       state_q, state_d;
  logic [WIDTH-1:0] grant_q, grant_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;

  logic [WIDTH-1:0] masked_req_c;
  logic [WIDTH-1:0] masked_win_c;
  logic [WIDTH-1:0] raw_win_c;
  logic [WIDTH-1:0] winner_c;
  logic             masked_any_c;
  logic             raw_any_c;
  logic             owner_req_c;
  logic             at_limit_c;
  logic             release_c;

  assign masked_req_c = req & mask_q;

  rr_arbiter_bitscan #(.WIDTH(WIDTH)) u_scan_masked (
    .req      (masked_req_c),
    .lowest_c (masked_win_c),
    .any_c    (masked_any_c)
  );

  rr_arbiter_bitscan #(.WIDTH(WIDTH)) u_scan_raw (
    .req      (req),
    .lowest_c (raw_win_c),
    .any_c    (raw_any_c)
  );

  // Masked candidates win; an empty masked set wraps back to the lowest raw request.
  always_comb begin
    winner_c    = masked_any_c ? masked_win_c : raw_win_c;
    owner_req_c = |(req & grant_q);
    at_limit_c  = HOLD_EN && (hold_q == HOLD_LAST);
    release_c   = done || !owner_req_c || at_limit_c;

    state_d   = state_q;
    grant_d   = grant_q;
    mask_d    = mask_q;
    idx_d     = idx_q;
    hold_d    = hold_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (raw_any_c) begin
          state_d = GRANTED;
          grant_d = winner_c;
          idx_d   = IDX_W'(onehot_to_idx(ONEHOT_MAX_W'(winner_c)));
          busy_d  = 1'b1;
          // Next priority starts strictly above the winner; MSB winner leaves mask empty.
          mask_d  = ~(winner_c | (winner_c - WIDTH'(1)));
          hold_d  = '0;
        end
      end
      GRANTED: begin
        if (release_c) begin
          state_d   = IDLE;
          grant_d   = '0;
          idx_d     = '0;
          busy_d    = 1'b0;
          timeout_d = at_limit_c && !done && owner_req_c;
        end else if (hold_q != '1) begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        idx_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      mask_q    <= '1;
      idx_q     <= '0;
      hold_q    <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      mask_q    <= mask_d;
      idx_q     <= idx_d;
      hold_q    <= hold_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant     = grant_q;
  assign grant_idx = idx_q;
  assign busy      = busy_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: directed WIDTH=4 scenarios plus randomized WIDTH=16 run against a reference model.
module tb_rr_arbiter;

  localparam int unsigned WA     = 4;
  localparam int unsigned WC     = 16;
  localparam int          HOLD_B = 3;
  localparam int          HOLD_C = 5;
  localparam int          N_RAND = 20000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_a, done_a, busy_a, to_a;
  logic [WA-1:0] req_a, grant_a;
  logic [1:0]    idx_a;
  logic          rst_b, done_b, busy_b, to_b;
  logic [WA-1:0] req_b, grant_b;
  logic [1:0]    idx_b;
  logic          rst_c, done_c, busy_c, to_c;
  logic [WC-1:0] req_c, grant_c;
  logic [3:0]    idx_c;

  rr_arbiter #(.WIDTH(WA), .MAX_HOLD(0)) dut_a (
    .clk(clk), .rst(rst_a), .req(req_a), .done(done_a),
    .grant(grant_a), .grant_idx(idx_a), .busy(busy_a), .timeout(to_a)
  );

  rr_arbiter #(.WIDTH(WA), .MAX_HOLD(HOLD_B)) dut_b (
    .clk(clk), .rst(rst_b), .req(req_b), .done(done_b),
    .grant(grant_b), .grant_idx(idx_b), .busy(busy_b), .timeout(to_b)
  );

  rr_arbiter #(.WIDTH(WC), .MAX_HOLD(HOLD_C)) dut_c (
    .clk(clk), .rst(rst_c), .req(req_c), .done(done_c),
    .grant(grant_c), .grant_idx(idx_c), .busy(busy_c), .timeout(to_c)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One grant on dut_a, released by a single-cycle done, then the mandatory idle gap.
  task automatic grant_cycle(input string tag, input logic [3:0] eg, input int ei);
    tick();
    check_eq({tag, "_grant"}, 32'(grant_a), 32'(eg));
    check_eq({tag, "_idx"},   32'(idx_a),   32'(ei));
    check_eq({tag, "_busy"},  32'(busy_a),  32'd1);
    done_a = 1'b1;
    tick();
    done_a = 1'b0;
    check_eq({tag, "_gap"},     32'(grant_a), 32'd0);
    check_eq({tag, "_gapbusy"}, 32'(busy_a),  32'd0);
  endtask

  // Reference model: owner index (-1 idle), last winner, cycles held.
  int   m_owner = -1;
  int   m_last  = -1;
  int   m_held  = 0;
  logic m_to    = 1'b0;

  task automatic model_step(input logic r_rst, input logic [WC-1:0] r, input logic d);
    m_to = 1'b0;
    if (r_rst) begin
      m_owner = -1;
      m_last  = -1;
      m_held  = 0;
    end else if (m_owner < 0) begin
      // Circular search starting just after the previous winner.
      for (int k = 1; k <= int'(WC); k++) begin
        int c;
        c = (m_last + k) % int'(WC);
        if (m_owner < 0 && r[c]) begin
          m_owner = c;
          m_last  = c;
          m_held  = 0;
        end
      end
    end else begin
      logic lim;
      lim = (m_held == HOLD_C - 1);
      if (d || !r[m_owner] || lim) begin
        m_to    = lim && !d && r[m_owner];
        m_owner = -1;
      end else begin
        m_held++;
      end
    end
  endtask

  logic [3:0] seq1 [4] = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
  int         idx1 [4] = '{1, 3, 1, 3};
  logic [3:0] seq2 [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  int         idx2 [5] = '{0, 1, 2, 3, 0};

  initial begin
    logic [WC-1:0] req_prev;
    logic [WC-1:0] grant_prev;
    logic          rst_prev;
    logic          done_prev;
    int            waits [WC];
    int            max_wait;

    rst_a = 1'b1; req_a = '0; done_a = 1'b0;
    rst_b = 1'b1; req_b = '0; done_b = 1'b0;
    rst_c = 1'b1; req_c = '0; done_c = 1'b0;

    // Reset state
    tick();
    check_eq("rst_grant",   32'(grant_a), 32'd0);
    check_eq("rst_idx",     32'(idx_a),   32'd0);
    check_eq("rst_busy",    32'(busy_a),  32'd0);
    check_eq("rst_timeout", 32'(to_a),    32'd0);

    // Alternating pair with a done per grant
    rst_a = 1'b0;
    req_a = 4'b1010;
    for (int i = 0; i < 4; i++) grant_cycle("alt", seq1[i], idx1[i]);

    // Full rotation with wrap
    req_a = 4'b1111;
    for (int i = 0; i < 5; i++) grant_cycle("rot", seq2[i], idx2[i]);

    // Owner drops its request
    req_a = 4'b0110;
    tick();
    check_eq("drop_grant", 32'(grant_a), 32'b0010);
    req_a = 4'b0100;
    tick();
    check_eq("drop_release", 32'(grant_a), 32'd0);
    check_eq("drop_timeout", 32'(to_a),    32'd0);
    tick();
    check_eq("drop_next", 32'(grant_a), 32'b0100);

    // Reset in the middle of a grant
    done_a = 1'b1;
    tick();
    done_a = 1'b0;
    check_eq("pre_rst_gap", 32'(grant_a), 32'd0);
    req_a = 4'b1000;
    tick();
    check_eq("pre_rst_grant", 32'(grant_a), 32'b1000);
    req_a = 4'b1001;
    rst_a = 1'b1;
    tick();
    check_eq("midrst_grant",   32'(grant_a), 32'd0);
    check_eq("midrst_busy",    32'(busy_a),  32'd0);
    check_eq("midrst_timeout", 32'(to_a),    32'd0);
    rst_a = 1'b0;
    tick();
    check_eq("postrst_grant", 32'(grant_a), 32'b0001);

    // Reset must restore the all-ones mask (otherwise bit 1 would win here)
    rst_a = 1'b1;
    req_a = 4'b0011;
    tick();
    check_eq("mask_rst_gap", 32'(grant_a), 32'd0);
    rst_a = 1'b0;
    tick();
    check_eq("mask_rst_grant", 32'(grant_a), 32'b0001);

    // Hold limit on dut_b
    rst_b = 1'b0;
    req_b = 4'b0100;
    for (int i = 0; i < HOLD_B; i++) begin
      tick();
      check_eq("hold_grant",   32'(grant_b), 32'b0100);
      check_eq("hold_timeout", 32'(to_b),    32'd0);
    end
    tick();
    check_eq("limit_grant",   32'(grant_b), 32'd0);
    check_eq("limit_timeout", 32'(to_b),    32'd1);
    check_eq("limit_busy",    32'(busy_b),  32'd0);
    tick();
    check_eq("regrant",         32'(grant_b), 32'b0100);
    check_eq("regrant_timeout", 32'(to_b),    32'd0);
    tick();
    tick();
    done_b = 1'b1;
    tick();
    done_b = 1'b0;
    check_eq("done_at_limit_grant",   32'(grant_b), 32'd0);
    check_eq("done_at_limit_timeout", 32'(to_b),    32'd0);

    // Randomized run on dut_c against the model
    for (int i = 0; i < int'(WC); i++) waits[i] = 0;
    max_wait   = 0;
    grant_prev = '0;
    for (int n = 0; n < N_RAND; n++) begin
      req_prev  = req_c;
      rst_prev  = rst_c;
      done_prev = done_c;
      tick();
      model_step(rst_prev, req_prev, done_prev);
      check_eq("rand_grant",   32'(grant_c), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
      check_eq("rand_idx",     32'(idx_c),   (m_owner >= 0) ? 32'(m_owner) : 32'd0);
      check_eq("rand_busy",    32'(busy_c),  32'(m_owner >= 0));
      check_eq("rand_timeout", 32'(to_c),    32'(m_to));

      for (int i = 0; i < int'(WC); i++) begin
        if (rst_prev || !req_prev[i]) waits[i] = 0;
        else if (grant_c != '0 && grant_prev == '0) begin
          if (grant_c[i]) waits[i] = 0;
          else begin
            waits[i]++;
            if (waits[i] > max_wait) max_wait = waits[i];
          end
        end
      end
      grant_prev = grant_c;

      rst_c  = (n < 2) || ($urandom_range(0, 999) == 0);
      done_c = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < int'(WC); i++) begin
        if ($urandom_range(0, 7) == 0) req_c[i] = ~req_c[i];
      end
    end
    check_eq("fairness_bound", 32'(max_wait < int'(WC)), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
